// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared constants, state enum and line type for the cache-line adaptor
package rv32i_types;

  localparam int LINE_W     = 256;
  localparam int BEAT_W     = 64;
  localparam int BEATS      = LINE_W / BEAT_W;
  localparam int BEAT_IDX_W = $clog2(BEATS);

  typedef logic [LINE_W-1:0] cacheline_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } adaptor_state_t;

  // Bursts always start on a line boundary: drop the byte-in-line offset.
  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return addr & ~32'h0000_001F;
  endfunction

endpackage

// File: rtl/line_beat_buf.sv
// rtl/line_beat_buf.sv - one cache line of storage with full-line load, per-beat write and per-beat read
module line_beat_buf
  import rv32i_types::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [LINE_W-1:0]     load_line_i,
  input  logic                  wr_en_i,
  input  logic [BEAT_IDX_W-1:0] wr_idx_i,
  input  logic [BEAT_W-1:0]     wr_beat_i,
  input  logic [BEAT_IDX_W-1:0] rd_idx_i,
  output logic [BEAT_W-1:0]     rd_beat_o,
  output logic [LINE_W-1:0]     line_o
);

  cacheline_t line_q;

  // Whole-line load wins over a single-beat write; both are never requested together by the adaptor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= '0;
    end else if (load_i) begin
      line_q <= load_line_i;
    end else if (wr_en_i) begin
      line_q[wr_idx_i*BEAT_W +: BEAT_W] <= wr_beat_i;
    end
  end

  assign rd_beat_o = line_q[rd_idx_i*BEAT_W +: BEAT_W];
  assign line_o    = line_q;

endmodule

// File: rtl/cacheline_adaptor.sv
// rtl/cacheline_adaptor.sv - 256-bit line to 4x64-bit burst sequencer; CACHELINE_ADAPTOR_RESP_BYPASS_EN drops the DONE state
module cacheline_adaptor #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       line_address,
  output logic [LINE_W-1:0] line_rdata,
  input  logic [LINE_W-1:0] line_wdata,
  input  logic              line_read,
  input  logic              line_write,
  output logic              line_resp,
  output logic [31:0]       burst_address,
  input  logic [BEAT_W-1:0] burst_rdata,
  output logic [BEAT_W-1:0] burst_wdata,
  output logic              burst_read,
  output logic              burst_write,
  input  logic              burst_resp
);

  import rv32i_types::*;

  localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BEATS - 1);

  adaptor_state_t        state_q;
  logic [BEAT_IDX_W-1:0] beat_cnt_q;
  logic [31:0]           address_q;

  logic                  accept_d;
  logic                  last_beat_d;
  logic                  rd_beat_we_d;

  logic [LINE_W-1:0]     rd_line;
  logic [LINE_W-1:0]     wr_line_unused;
  logic [BEAT_W-1:0]     wr_beat;
  logic [BEAT_W-1:0]     rd_beat_unused;

  assign accept_d     = (state_q == ST_IDLE) && (line_read || line_write);
  assign last_beat_d  = burst_resp && (beat_cnt_q == LAST_BEAT);
  assign rd_beat_we_d = (state_q == ST_RD) && burst_resp;

  // Line FSM: accept in IDLE (write has priority), count beats on burst_resp, finish after beat 3.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
      address_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          beat_cnt_q <= '0;
          if (line_write) begin
            state_q   <= ST_WR;
            address_q <= line_align(line_address);
          end else if (line_read) begin
            state_q   <= ST_RD;
            address_q <= line_align(line_address);
          end
        end
        ST_RD, ST_WR: begin
          if (burst_resp) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (last_beat_d) begin
`ifdef CACHELINE_ADAPTOR_RESP_BYPASS_EN
              state_q <= ST_IDLE;
`else
              state_q <= ST_DONE;
`endif
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Read line assembly: one beat lands per accepted read beat, in order 0..3.
  line_beat_buf u_rd_buf (
    .clk         (clk),
    .rst_n       (rst),
    .load_i      (1'b0),
    .load_line_i ('0),
    .wr_en_i     (rd_beat_we_d),
    .wr_idx_i    (beat_cnt_q),
    .wr_beat_i   (burst_rdata),
    .rd_idx_i    (beat_cnt_q),
    .rd_beat_o   (rd_beat_unused),
    .line_o      (rd_line)
  );

  // Write line capture: whole line latched on acceptance, presented one beat at a time.
  line_beat_buf u_wr_buf (
    .clk         (clk),
    .rst_n       (rst),
    .load_i      (accept_d),
    .load_line_i (line_wdata),
    .wr_en_i     (1'b0),
    .wr_idx_i    ('0),
    .wr_beat_i   ('0),
    .rd_idx_i    (beat_cnt_q),
    .rd_beat_o   (wr_beat),
    .line_o      (wr_line_unused)
  );

  // Output decode: burst side depends only on registered state; line side adds the bypass merge when enabled.
  always_comb begin
    burst_read    = (state_q == ST_RD);
    burst_write   = (state_q == ST_WR);
    burst_address = ((state_q == ST_RD) || (state_q == ST_WR)) ? address_q : '0;
    burst_wdata   = (state_q == ST_WR) ? wr_beat : '0;
    line_rdata    = rd_line;
`ifdef CACHELINE_ADAPTOR_RESP_BYPASS_EN
    line_resp     = ((state_q == ST_RD) || (state_q == ST_WR)) && last_beat_d;
    if ((state_q == ST_RD) && last_beat_d) begin
      line_rdata[LINE_W-1 -: BEAT_W] = burst_rdata;
    end
`else
    line_resp     = (state_q == ST_DONE);
`endif
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb/tb_cacheline_adaptor.sv - directed self-checking bench for cacheline_adaptor
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [31:0]  line_address = '0;
  logic [255:0] line_rdata;
  logic [255:0] line_wdata = '0;
  logic         line_read = 1'b0;
  logic         line_write = 1'b0;
  logic         line_resp;
  logic [31:0]  burst_address;
  logic [63:0]  burst_rdata = '0;
  logic [63:0]  burst_wdata;
  logic         burst_read;
  logic         burst_write;
  logic         burst_resp = 1'b0;

  int vectors = 0;
  int errors  = 0;

`ifdef CACHELINE_ADAPTOR_RESP_BYPASS_EN
  localparam int RESP_CYC = 4;
  localparam bit BYPASS   = 1'b1;
`else
  localparam int RESP_CYC = 5;
  localparam bit BYPASS   = 1'b0;
`endif

  localparam logic [255:0] RD_LINE  = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                       64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
  localparam logic [255:0] WR_LINE  = {64'h3333_3333_3333_3330, 64'h2222_2222_2222_2220,
                                       64'h1111_1111_1111_1110, 64'h0F0F_0F0F_0F0F_0F00};
  localparam logic [255:0] WB_LINE  = {64'h4444_0000_0000_0004, 64'h5555_0000_0000_0005,
                                       64'h6666_0000_0000_0006, 64'h7777_0000_0000_0007};
  localparam logic [255:0] FRESH    = {64'hEEEE_0000_1111_0003, 64'hEEEE_0000_1111_0002,
                                       64'hEEEE_0000_1111_0001, 64'hEEEE_0000_1111_0000};
  localparam logic [255:0] B2R_LINE = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                       64'h0F1E_2D3C_4B5A_6978, 64'h8796_A5B4_C3D2_E1F0};

  cacheline_adaptor dut (
    .clk           (clk),
    .rst           (rst),
    .line_address  (line_address),
    .line_rdata    (line_rdata),
    .line_wdata    (line_wdata),
    .line_read     (line_read),
    .line_write    (line_write),
    .line_resp     (line_resp),
    .burst_address (burst_address),
    .burst_rdata   (burst_rdata),
    .burst_wdata   (burst_wdata),
    .burst_read    (burst_read),
    .burst_write   (burst_write),
    .burst_resp    (burst_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait line transfer starting in the current (IDLE) cycle; returns the cycle index of line_resp.
  task automatic run_line(input string tag, input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [255:0] data, input logic [31:0] exp_addr, output int resp_cyc);
    int cyc;
    int beat;
    cyc = 0;
    beat = 0;
    resp_cyc = -1;
    line_address = addr;
    line_wdata   = data;
    line_read    = rd;
    line_write   = wr;
    burst_resp   = 1'b0;
    #1;
    chk({tag, "_c0_idle"}, {burst_read, burst_write, line_resp}, 3'b000);
    while (resp_cyc < 0 && cyc < 20) begin
      tick();
      cyc++;
      burst_resp  = (beat < 4);
      burst_rdata = (beat < 4) ? data[beat*64 +: 64] : 64'h0;
      #1;
      if (beat < 4) begin
        chk({tag, "_bread"}, burst_read, !wr);
        chk({tag, "_bwrite"}, burst_write, wr);
        chk({tag, "_baddr"}, burst_address, exp_addr);
        if (wr) chk({tag, "_bwdata"}, burst_wdata, data[beat*64 +: 64]);
        beat++;
      end
      if (line_resp) begin
        resp_cyc = cyc;
        line_read  = 1'b0;
        line_write = 1'b0;
        if (!wr) chk({tag, "_rdata"}, line_rdata, data);
      end
    end
    chk({tag, "_resp_cyc"}, resp_cyc, RESP_CYC);
  endtask

  initial begin
    int rc;
    int rc2;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_line_resp", line_resp, 1'b0);
    chk("rst_burst_read", burst_read, 1'b0);
    chk("rst_burst_write", burst_write, 1'b0);
    chk("rst_burst_addr", burst_address, 32'h0);
    chk("rst_burst_wdata", burst_wdata, 64'h0);
    chk("rst_line_rdata", line_rdata, 256'h0);
    rst = 1'b1;
    tick();

    // Read, zero wait
    run_line("rd0", 1'b1, 1'b0, 32'h1234_5678, RD_LINE, 32'h1234_5660, rc);
    tick();
    burst_resp = 1'b0;
    #1;
    chk("rd0_resp_pulse", line_resp, 1'b0);
    chk("rd0_idle_bread", burst_read, 1'b0);
    chk("rd0_rdata_held", line_rdata, RD_LINE);

    // Write with a wait cycle before every beat
    line_address = 32'hABCD_EF3F;
    line_wdata   = WR_LINE;
    line_write   = 1'b1;
    #1;
    chk("wrw_c0_bwrite", burst_write, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      tick();
      burst_resp = (c % 2 == 0);
      #1;
      chk("wrw_bwrite", burst_write, 1'b1);
      chk("wrw_bread", burst_read, 1'b0);
      chk("wrw_baddr", burst_address, 32'hABCD_EF20);
      chk("wrw_bwdata", burst_wdata, WR_LINE[((c-1)/2)*64 +: 64]);
      chk("wrw_resp_early", line_resp, BYPASS && (c == 8));
      if (c == 8 && BYPASS) line_write = 1'b0;
    end
    tick();
    burst_resp = 1'b0;
    #1;
    chk("wrw_done_resp", line_resp, !BYPASS);
    chk("wrw_done_bwrite", burst_write, 1'b0);
    line_write = 1'b0;
    tick();
    #1;
    chk("wrw_resp_pulse", line_resp, 1'b0);
    chk("wrw_rdata_kept", line_rdata, RD_LINE);

    // Simultaneous read and write: write wins
    run_line("both", 1'b1, 1'b1, 32'h0000_0040, WB_LINE, 32'h0000_0040, rc);
    tick();
    burst_resp = 1'b0;
    #1;
    chk("both_resp_pulse", line_resp, 1'b0);
    chk("both_rdata_kept", line_rdata, RD_LINE);

    // Reset in the middle of a read
    line_address = 32'h0000_0100;
    line_read    = 1'b1;
    tick();
    burst_resp  = 1'b1;
    burst_rdata = 64'h9999_0000_0000_0000;
    #1;
    chk("mrst_bread_b0", burst_read, 1'b1);
    tick();
    burst_rdata = 64'h9999_0000_0000_0001;
    tick();
    burst_rdata = 64'h9999_0000_0000_0002;
    rst = 1'b0;
    #1;
    chk("mrst_bread", burst_read, 1'b0);
    chk("mrst_bwrite", burst_write, 1'b0);
    chk("mrst_baddr", burst_address, 32'h0);
    chk("mrst_resp", line_resp, 1'b0);
    chk("mrst_rdata", line_rdata, 256'h0);
    line_read  = 1'b0;
    burst_resp = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("mrst_rel_resp", line_resp, 1'b0);
    chk("mrst_rel_bread", burst_read, 1'b0);
    tick();
    run_line("post_rst", 1'b1, 1'b0, 32'h0000_0123, FRESH, 32'h0000_0120, rc);

    // Back-to-back read then write
    tick();
    burst_resp = 1'b0;
    run_line("b2b_rd", 1'b1, 1'b0, 32'h8000_001F, B2R_LINE, 32'h8000_0000, rc);
    tick();
    run_line("b2b_wr", 1'b0, 1'b1, 32'h8000_0020, WR_LINE, 32'h8000_0020, rc2);
    chk("b2b_total_cycles", rc + 1 + rc2 + 1, BYPASS ? 10 : 12);
    tick();
    burst_resp = 1'b0;
    #1;
    chk("b2b_resp_pulse", line_resp, 1'b0);
    chk("b2b_rdata_kept", line_rdata, B2R_LINE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
